// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the nonce scheduler and its helpers:
//   SHA256_IV        standard SHA-256 initial chaining value (second hash)
//   STATUS_WAITING   status byte reported while idle
//   STATUS_WORKING   status byte reported while a sweep is running
//   PAD1_LEN         bit length of the 80-byte header (first hash padding)
//   PAD2_LEN         bit length of a 32-byte digest (second hash padding)
//   state_t          scheduler FSM states
// ---------------------------------------------------------------------------
package miner_pkg;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [7:0] STATUS_WAITING = 8'hA0;
    localparam logic [7:0] STATUS_WORKING = 8'hA1;

    localparam logic [63:0] PAD1_LEN = 64'd640;
    localparam logic [63:0] PAD2_LEN = 64'd256;

    typedef enum logic [2:0] {
        IDLE,
        H1_REQ,
        H1_WAIT,
        H2_REQ,
        H2_WAIT,
        CHECK
    } state_t;

endpackage

// File: rtl/miner_target_check.sv
// ---------------------------------------------------------------------------
// miner_target_check
// Difficulty test on a final double-SHA digest. The hash is compared as a
// byte-reversed number, so its leading zeros sit at the low end of the
// digest word as delivered by the core.
//   digest  in  256  final digest (second compression output)
//   hit     out 1    low DIFF_BITS bits of digest are all zero
// DIFF_BITS is expected to be a multiple of 8 in 8..64.
// ---------------------------------------------------------------------------
module miner_target_check #(
    parameter int DIFF_BITS = 32
) (
    input  logic [255:0] digest,
    output logic         hit
);

    assign hit = (digest[DIFF_BITS-1:0] == '0);

endmodule

// File: rtl/miner_nonce_sched.sv
// ---------------------------------------------------------------------------
// miner_nonce_sched
// Drives one shared SHA-256 compression core through the Bitcoin double
// hash for each nonce of a job, stopping at the first qualifying nonce or
// when the range is used up.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   job_valid           pulse: load job_h_prev/job_m and start a sweep
//   job_h_prev, job_m   midstate of header bytes 0..63, header bytes 64..75
//   nonce_start/_end    inclusive sweep range (NONCE_RANGE_EN builds only)
//   abort               pulse: drop the current sweep
//   sha_ready/start     core handshake; start only issued while ready
//   sha_iv, sha_block   chaining value / message block for the core
//   sha_done/digest     core result pulse and digest (IV already added)
//   busy, status_code   sweep in progress, A1/A0 status byte
//   found, found_nonce  sticky hit flag and winning nonce
//   exhausted           sticky: range finished with no hit
//
// Configuration macro: NONCE_RANGE_EN adds nonce_start/nonce_end; without
// it the sweep covers the full 0..2^32-1 space.
// ---------------------------------------------------------------------------
module miner_nonce_sched
    import miner_pkg::*;
#(
    parameter int DIFF_BITS = 32,
    parameter int NONCE_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_valid,
    input  logic [255:0]       job_h_prev,
    input  logic [95:0]        job_m,
`ifdef NONCE_RANGE_EN
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
`endif
    input  logic               abort,
    input  logic               sha_ready,
    output logic               sha_start,
    output logic [255:0]       sha_iv,
    output logic [511:0]       sha_block,
    input  logic               sha_done,
    input  logic [255:0]       sha_digest,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [7:0]         status_code
);

    state_t               state, state_nx;
    logic [NONCE_W-1:0]   nonce;
    logic [255:0]         h_prev;
    logic [95:0]          m;
    logic [255:0]         d1;
    logic [255:0]         d2;
    logic                 hit;
    logic [NONCE_W-1:0]   start_val;
    logic [NONCE_W-1:0]   end_val;
    logic                 range_bad;

`ifdef NONCE_RANGE_EN
    logic [NONCE_W-1:0]   end_q;

    assign start_val = nonce_start;
    assign end_val   = end_q;
    assign range_bad = (nonce_start > nonce_end);
`else
    assign start_val = '0;
    assign end_val   = '1;
    assign range_bad = 1'b0;
`endif

    miner_target_check #(
        .DIFF_BITS (DIFF_BITS)
    ) u_target_check (
        .digest (d2),
        .hit    (hit)
    );

    // Next state and start pulse. A new job beats abort, and both beat any
    // pending request so a start is never issued in a cycle that tears the
    // sweep down (that would leave an orphan request in the core).
    always_comb begin
        state_nx  = state;
        sha_start = 1'b0;
        if (job_valid) begin
            state_nx = range_bad ? IDLE : H1_REQ;
        end else if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = IDLE;
                H1_REQ: begin
                    if (sha_ready) begin
                        sha_start = 1'b1;
                        state_nx  = H1_WAIT;
                    end
                end
                H1_WAIT: if (sha_done) state_nx = H2_REQ;
                H2_REQ: begin
                    if (sha_ready) begin
                        sha_start = 1'b1;
                        state_nx  = H2_WAIT;
                    end
                end
                H2_WAIT: if (sha_done) state_nx = CHECK;
                CHECK: begin
                    if (hit || nonce == end_val) state_nx = IDLE;
                    else                         state_nx = H1_REQ;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            nonce       <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_nonce <= '0;
        end else begin
            state <= state_nx;
            if (job_valid) begin
                h_prev    <= job_h_prev;
                m         <= job_m;
                nonce     <= start_val;
                found     <= 1'b0;
                exhausted <= range_bad;
`ifdef NONCE_RANGE_EN
                end_q     <= nonce_end;
`endif
            end else if (!abort) begin
                case (state)
                    H1_WAIT: if (sha_done) d1 <= sha_digest;
                    H2_WAIT: if (sha_done) d2 <= sha_digest;
                    CHECK: begin
                        if (hit) begin
                            found       <= 1'b1;
                            found_nonce <= nonce;
                        end else if (nonce == end_val) begin
                            // stop here; the counter must not wrap
                            exhausted <= 1'b1;
                        end else begin
                            nonce <= nonce + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Block assembly: first hash finishes the 80-byte header, second hash
    // re-hashes the 32-byte first digest from the standard IV.
    always_comb begin
        sha_iv    = h_prev;
        sha_block = {m, nonce, 1'b1, 319'b0, PAD1_LEN};
        if (state == H2_REQ) begin
            sha_iv    = SHA256_IV;
            sha_block = {d1, 1'b1, 191'b0, PAD2_LEN};
        end
    end

    assign busy        = (state != IDLE);
    assign status_code = busy ? STATUS_WORKING : STATUS_WAITING;

endmodule

// File: tb/tb_miner_nonce_sched.sv
// ---------------------------------------------------------------------------
// tb_miner_nonce_sched
// Bench for miner_nonce_sched with a behavioural SHA core stand-in. The
// stand-in returns a cheap mixing function of (iv, block) instead of a real
// compression, and can force the final digest to meet / miss the target at
// chosen nonces so sweep lengths stay short and predictable.
// ---------------------------------------------------------------------------
module tb_miner_nonce_sched;

    localparam int DB = 8;
    localparam logic [255:0] IV_REF = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         job_valid = 1'b0;
    logic [255:0] job_h_prev = '0;
    logic [95:0]  job_m = '0;
`ifdef NONCE_RANGE_EN
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '1;
`endif
    logic         abort = 1'b0;
    logic         sha_ready;
    logic         sha_start;
    logic [255:0] sha_iv;
    logic [511:0] sha_block;
    logic         sha_done;
    logic [255:0] sha_digest;
    logic         busy, found, exhausted;
    logic [31:0]  found_nonce;
    logic [7:0]   status_code;

    int n_tests = 0;
    int n_fail  = 0;

    // core stand-in state
    logic         core_busy = 1'b0;
    int           core_cnt = 0;
    int           core_lat = 4;
    logic         core_done = 1'b0;
    logic [255:0] core_dig = '0;
    logic [255:0] core_pend = '0;
    logic [31:0]  last_nonce = '0;
    logic         hold_ready = 1'b0;
    logic         stray_done = 1'b0;
    int           core_mode = 0;
    logic [31:0]  force_nonce = '0;
    int           start_cnt = 0;
    int           viol_cnt = 0;

    logic [255:0] log_iv[$];
    logic [511:0] log_blk[$];
    logic [255:0] exp_iv[$];
    logic [511:0] exp_blk[$];

    miner_nonce_sched #(
        .DIFF_BITS (DB),
        .NONCE_W   (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .job_valid   (job_valid),
        .job_h_prev  (job_h_prev),
        .job_m       (job_m),
`ifdef NONCE_RANGE_EN
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
`endif
        .abort       (abort),
        .sha_ready   (sha_ready),
        .sha_start   (sha_start),
        .sha_iv      (sha_iv),
        .sha_block   (sha_block),
        .sha_done    (sha_done),
        .sha_digest  (sha_digest),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .found_nonce (found_nonce),
        .status_code (status_code)
    );

    initial forever #5 clk = ~clk;

    // Stand-in compression: FNV-style fold of block and IV, then expanded.
    function automatic logic [255:0] mix(input logic [255:0] iv, input logic [511:0] b);
        logic [31:0]  x;
        logic [255:0] r;
        x = 32'h811c9dc5;
        for (int i = 0; i < 16; i++) begin
            x = (x ^ b[i*32 +: 32]) * 32'h01000193;
            x = x ^ (x >> 15);
        end
        for (int i = 0; i < 8; i++) begin
            x = (x ^ iv[i*32 +: 32]) * 32'h01000193;
            x = x ^ (x >> 13);
        end
        for (int k = 0; k < 8; k++) begin
            x = x * 32'h9E3779B1 + 32'(k);
            r[k*32 +: 32] = x ^ (x >> 16);
        end
        return r;
    endfunction

    // mode 0: natural digests; 1: also force a hit at fn; 2: hit only at fn
    function automatic logic [255:0] shape(input logic [255:0] d, input logic [31:0] n,
                                           input int mode, input logic [31:0] fn);
        logic [255:0] r;
        r = d;
        if (mode != 0 && n == fn) r[DB-1:0] = '0;
        else if (mode == 2)       r[0] = 1'b1;
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [95:0] rnd96();
        logic [95:0] r;
        for (int i = 0; i < 3; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    assign sha_ready  = !core_busy && !hold_ready;
    assign sha_done   = core_done | stray_done;
    // a stray done carries an all-zero digest, which would look like a hit
    assign sha_digest = stray_done ? '0 : core_dig;

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_busy) begin
            if (core_cnt <= 1) begin
                core_busy <= 1'b0;
                core_done <= 1'b1;
                core_dig  <= core_pend;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
        if (sha_start) begin
            start_cnt <= start_cnt + 1;
            if (!sha_ready) viol_cnt <= viol_cnt + 1;
            log_iv.push_back(sha_iv);
            log_blk.push_back(sha_block);
            core_busy <= 1'b1;
            core_cnt  <= core_lat;
            if (sha_block[63:0] == 64'd256) begin
                core_pend <= shape(mix(sha_iv, sha_block), last_nonce, core_mode, force_nonce);
            end else begin
                core_pend  <= mix(sha_iv, sha_block);
                last_nonce <= sha_block[415:384];
            end
        end
    end

    // Reference sweep: walk the nonce range applying the double-hash and
    // target rules, recording every block the scheduler should issue.
    task automatic model_sweep(input logic [255:0] hp, input logic [95:0] m,
                               input logic [31:0] st, input logic [31:0] en,
                               input int mode, input logic [31:0] fn,
                               output bit hit, output logic [31:0] hn, output int pulses);
        logic [31:0]  n;
        logic [511:0] b1, b2;
        logic [255:0] d1, d2;
        exp_iv.delete();
        exp_blk.delete();
        hit = 0;
        hn = '0;
        pulses = 0;
        if (st > en) return;
        n = st;
        for (int k = 0; k < 2000; k++) begin
            b1 = {m, n, 1'b1, 319'b0, 64'd640};
            d1 = mix(hp, b1);
            b2 = {d1, 1'b1, 191'b0, 64'd256};
            d2 = shape(mix(IV_REF, b2), n, mode, fn);
            exp_iv.push_back(hp);     exp_blk.push_back(b1);
            exp_iv.push_back(IV_REF); exp_blk.push_back(b2);
            pulses += 2;
            if (d2[DB-1:0] == '0) begin
                hit = 1;
                hn = n;
                return;
            end
            if (n == en) return;
            n = n + 1;
        end
    endtask

    task automatic run_job(input string nm, input logic [255:0] hp, input logic [95:0] m,
                           input logic [31:0] st, input logic [31:0] en,
                           input int mode, input logic [31:0] fn);
        bit          e_hit;
        logic [31:0] e_n;
        int          e_p, base, s0, t, err;
        core_mode   = mode;
        force_nonce = fn;
        model_sweep(hp, m, st, en, mode, fn, e_hit, e_n, e_p);
        @(negedge clk);
        base = log_blk.size();
        s0 = start_cnt;
        job_valid  = 1'b1;
        job_h_prev = hp;
        job_m      = m;
`ifdef NONCE_RANGE_EN
        nonce_start = st;
        nonce_end   = en;
`endif
        @(negedge clk);
        job_valid = 1'b0;
        if (st <= en) begin
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_rise got %0b want 1", nm, busy);
            end
        end
        t = 0;
        while (busy === 1'b1 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (t >= LIMIT) begin
            n_fail++;
            $display("FAIL %s timeout busy still %0b after %0d cycles", nm, busy, t);
        end
        n_tests++;
        if (found !== e_hit) begin
            n_fail++;
            $display("FAIL %s found got %0b want %0b", nm, found, e_hit);
        end
        n_tests++;
        if (exhausted !== ~e_hit) begin
            n_fail++;
            $display("FAIL %s exhausted got %0b want %0b", nm, exhausted, ~e_hit);
        end
        if (e_hit) begin
            n_tests++;
            if (found_nonce !== e_n) begin
                n_fail++;
                $display("FAIL %s found_nonce got %h want %h", nm, found_nonce, e_n);
            end
        end
        n_tests++;
        if (start_cnt - s0 !== e_p) begin
            n_fail++;
            $display("FAIL %s start_pulses got %0d want %0d", nm, start_cnt - s0, e_p);
        end
        err = 0;
        for (int i = 0; i < exp_blk.size(); i++) begin
            if (base + i >= log_blk.size()) err++;
            else if (log_blk[base+i] !== exp_blk[i] || log_iv[base+i] !== exp_iv[i]) err++;
        end
        n_tests++;
        if (err != 0) begin
            n_fail++;
            $display("FAIL %s block_stream got %0d bad requests want 0", nm, err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || sha_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy/start got %0b/%0b want 0/0", busy, sha_start);
        end
        n_tests++;
        if (found !== 1'b0 || exhausted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset found/exhausted got %0b/%0b want 0/0", found, exhausted);
        end
        n_tests++;
        if (found_nonce !== 32'h0 || status_code !== 8'hA0) begin
            n_fail++;
            $display("FAIL reset nonce/status got %h/%h want 0/a0", found_nonce, status_code);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_hash();
        int t, s0;
        core_lat = 64;
        core_mode = 2;
        force_nonce = 0;
        @(negedge clk);
        s0 = start_cnt;
        job_valid = 1'b1; job_h_prev = rnd256(); job_m = rnd96();
`ifdef NONCE_RANGE_EN
        nonce_start = 0; nonce_end = '1;
`endif
        @(negedge clk);
        job_valid = 1'b0;
        t = 0;
        while (start_cnt == s0 && t < 20) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        n_tests++;
        if (status_code !== 8'hA1) begin
            n_fail++;
            $display("FAIL rst_mid status_busy got %h want a1", status_code);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || sha_start !== 1'b0 || status_code !== 8'hA0) begin
            n_fail++;
            $display("FAIL rst_mid after got busy=%0b start=%0b status=%h want 0 0 a0",
                     busy, sha_start, status_code);
        end
        s0 = start_cnt;
        repeat (70) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0 || start_cnt != s0) begin
            n_fail++;
            $display("FAIL rst_mid late_done got busy=%0b found=%0b exh=%0b starts=%0d want 0 0 0 0",
                     busy, found, exhausted, start_cnt - s0);
        end
        core_lat = 4;
    endtask

    task automatic test_ready_stall();
        int t, s0, base, s_hold;
        logic [255:0] hp;
        logic [95:0]  m;
        hp = rnd256(); m = rnd96();
        core_lat = 3; core_mode = 2; force_nonce = 0;
        @(negedge clk);
        s0 = start_cnt; base = log_blk.size();
        job_valid = 1'b1; job_h_prev = hp; job_m = m;
`ifdef NONCE_RANGE_EN
        nonce_start = 0; nonce_end = '1;
`endif
        @(negedge clk);
        job_valid = 1'b0;
        t = 0;
        while (sha_done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        hold_ready = 1'b1;
        s_hold = start_cnt;
        t = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sha_start !== 1'b0) t++;
        end
        n_tests++;
        if (t != 0 || start_cnt != s_hold || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall start_while_low got %0d pulses busy=%0b want 0 pulses busy=1",
                     t + start_cnt - s_hold, busy);
        end
        hold_ready = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 100) begin @(negedge clk); t++; end
        n_tests++;
        if (start_cnt - s0 != 2 || found !== 1'b1 || found_nonce !== 32'h0) begin
            n_fail++;
            $display("FAIL stall result got starts=%0d found=%0b nonce=%h want 2 1 0",
                     start_cnt - s0, found, found_nonce);
        end
        n_tests++;
        if (log_blk.size() < base + 2 ||
            log_blk[base+1][511:256] !== mix(hp, {m, 32'h0, 1'b1, 319'b0, 64'd640})) begin
            n_fail++;
            $display("FAIL stall d1_in_block got %h want %h",
                     (log_blk.size() < base + 2) ? 256'h0 : log_blk[base+1][511:256],
                     mix(hp, {m, 32'h0, 1'b1, 319'b0, 64'd640}));
        end
        core_lat = 4;
    endtask

    task automatic test_abort_restart();
        int t, s0, base;
        logic [95:0] m2;
        core_lat = 8; core_mode = 2; force_nonce = 2;
        @(negedge clk);
        s0 = start_cnt;
        job_valid = 1'b1; job_h_prev = rnd256(); job_m = rnd96();
`ifdef NONCE_RANGE_EN
        nonce_start = 0; nonce_end = '1;
`endif
        @(negedge clk);
        job_valid = 1'b0;
        t = 0;
        while (start_cnt < s0 + 2 && t < 100) begin @(negedge clk); t++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0) begin
            n_fail++;
            $display("FAIL abort state got busy=%0b found=%0b exh=%0b want 0 0 0",
                     busy, found, exhausted);
        end
        repeat (1) @(negedge clk);
        m2 = rnd96();
        base = log_blk.size();
        run_job("abort_restart", rnd256(), m2, 32'h0, 32'hFFFF_FFFF, 2, 1);
        n_tests++;
        if (log_blk.size() <= base || log_blk[base][511:384] !== {m2, 32'h0}) begin
            n_fail++;
            $display("FAIL abort first_block got %h want %h",
                     (log_blk.size() <= base) ? 128'h0 : log_blk[base][511:384], {m2, 32'h0});
        end
        core_lat = 4;
    endtask

    task automatic test_restart_busy();
        core_lat = 5; core_mode = 2; force_nonce = 40;
        @(negedge clk);
        job_valid = 1'b1; job_h_prev = rnd256(); job_m = rnd96();
`ifdef NONCE_RANGE_EN
        nonce_start = 0; nonce_end = '1;
`endif
        @(negedge clk);
        job_valid = 1'b0;
        repeat (31) @(negedge clk);
        run_job("restart_busy", rnd256(), rnd96(), 32'h0, 32'hFFFF_FFFF, 2, 4);
    endtask

    task automatic test_stray_done();
        int t, s0;
        logic [31:0] prev;
        prev = found_nonce;
        s0 = start_cnt;
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || start_cnt != s0 || found_nonce !== prev) begin
            n_fail++;
            $display("FAIL stray_idle got busy=%0b starts=%0d nonce=%h want 0 0 %h",
                     busy, start_cnt - s0, found_nonce, prev);
        end
        // stray done while parked in H1_REQ
        hold_ready = 1'b1; core_mode = 2; force_nonce = 2;
        job_valid = 1'b1; job_h_prev = rnd256(); job_m = rnd96();
`ifdef NONCE_RANGE_EN
        nonce_start = 0; nonce_end = '1;
`endif
        @(negedge clk);
        job_valid = 1'b0;
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (2) @(negedge clk);
        hold_ready = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 200) begin @(negedge clk); t++; end
        n_tests++;
        if (found !== 1'b1 || found_nonce !== 32'd2 || start_cnt - s0 != 6) begin
            n_fail++;
            $display("FAIL stray_req got found=%0b nonce=%h starts=%0d want 1 2 6",
                     found, found_nonce, start_cnt - s0);
        end
    endtask

`ifdef NONCE_RANGE_EN
    task automatic test_range();
        logic [255:0] hp;
        logic [95:0]  m;
        logic [31:0]  st;
        hp = rnd256(); m = rnd96();
        st = $urandom_range(32'h7fff_ffff, 0);
        core_lat = 3;
        run_job("range_hit", hp, m, st, st + 6, 2, st + 2);
        run_job("range_miss", hp, m, st, st + 3, 2, st + 10);
        run_job("range_single", hp, m, st + 1, st + 1, 2, st + 9);
        run_job("range_empty", hp, m, 32'd5, 32'd4, 2, 32'd5);
        run_job("range_top", hp, m, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 32'd0);
        core_lat = 4;
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_hash();
        core_lat = $urandom_range(6, 1);
        run_job("forced_nonce3", rnd256(), rnd96(), 32'h0, 32'hFFFF_FFFF, 2, 3);
        test_stray_done();
        for (int j = 0; j < 3; j++) begin
            core_lat = $urandom_range(6, 1);
            run_job("random_job", rnd256(), rnd96(), 32'h0, 32'hFFFF_FFFF, 1,
                    $urandom_range(150, 0));
        end
        test_ready_stall();
        test_abort_restart();
        test_restart_busy();
`ifdef NONCE_RANGE_EN
        test_range();
`endif
        n_tests++;
        if (viol_cnt != 0) begin
            n_fail++;
            $display("FAIL start_without_ready got %0d want 0", viol_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
